demux_buf1_4: RTL

DEMUX_BUF1_4 -- requirements
Module: demux_buf1_4

---
 rtl/demux_buf1_4.sv | 57 +++++
 1 files changed

// File: rtl/demux_buf1_4.sv
// rtl/demux_buf1_4.sv - 1-to-4 demultiplexer with a one-entry buffer per output channel
module demux_buf1_4 #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [4*WIDTH-1:0]   out_data,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [15:0]          acc_count,
    output logic                 busy
);

    logic [3:0]         full_q, full_d;
    logic [4*WIDTH-1:0] data_q, data_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               accept;
    logic [3:0]         pop;

    // A full channel can still take a word when its consumer drains it on the same edge.
    assign in_ready = !full_q[in_sel] || out_ready[in_sel];
    assign accept   = in_valid && in_ready;
    assign pop      = full_q & out_ready;

    always_comb begin
        full_d = full_q & ~pop;
        data_d = data_q;
        cnt_d  = cnt_q;
        if (accept) begin
            full_d[in_sel]                = 1'b1;
            data_d[in_sel*WIDTH +: WIDTH] = in_data;
            cnt_d                         = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            full_q <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = full_q;
    assign acc_count = cnt_q;
    assign busy      = |full_q;

endmodule
